// File: rtl/prog3_pkg.sv
// Shared types and constants for the byte-serial 4-bit pattern scanner.
package prog3_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } scan_state_t;

    localparam int STR_BYTES = 8;
    localparam int PAT_W     = 4;
    localparam int IN_WIN    = 5;
    localparam int SPAN_WIN  = 3;
    localparam int IDX_W     = $clog2(STR_BYTES);

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Data-memory read port shared between the scanner (master) and the memory (slave).
interface pattern_scan_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [7:0]        mem_rdata;

    modport master (output mem_addr, output mem_re, input mem_rdata);
    modport slave  (input mem_addr, input mem_re, output mem_rdata);
endinterface

// File: rtl/pattern_scan_ctrl_match.sv
// Combinational window matcher: counts in-byte and byte-spanning 4-bit pattern hits.
module pat_match_byte
    import prog3_pkg::*;
(
    input  logic [10:0]      w,
    input  logic [PAT_W-1:0] pat,
    input  logic             span_en,
    output logic [2:0]       in_cnt,
    output logic [1:0]       span_cnt,
    output logic             hit
);

    // w[7:0] is the current byte, w[10:8] the low bits of the previous byte.
    always_comb begin
        in_cnt   = '0;
        span_cnt = '0;
        for (int i = 0; i < IN_WIN; i++) begin
            if (w[7-i -: PAT_W] == pat) in_cnt = in_cnt + 3'd1;
        end
        for (int j = 0; j < SPAN_WIN; j++) begin
            if (span_en && (w[10-j -: PAT_W] == pat)) span_cnt = span_cnt + 2'd1;
        end
        hit = (in_cnt != 3'd0);
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Fetches an 8-byte string over a shared read port and counts 4-bit pattern matches.
module pattern_scan_ctrl
    import prog3_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [PAT_W-1:0]    pat,
    pattern_scan_ctrl_if.master mem,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    ctb,
    output logic [CNT_W-1:0]    cts,
    output logic [CNT_W-1:0]    cto
);

    scan_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] base_q;
    logic [PAT_W-1:0]  pat_q;
    logic [2:0]        prev_q;
    logic              vld_q;
    logic              first_q;
    logic [CNT_W-1:0]  ctb_q, cts_q, cto_q;
    logic [2:0]        in_cnt;
    logic [1:0]        span_cnt;
    logic              hit;
    logic              accept;

    assign accept = (state_q == S_IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: if (idx_q == IDX_W'(STR_BYTES - 1)) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
        mem.mem_re   = (state_q == S_FETCH);
        mem.mem_addr = mem.mem_re ? (base_q + ADDR_W'(idx_q)) : '0;
    end

    pat_match_byte u_match (
        .w        ({prev_q, mem.mem_rdata}),
        .pat      (pat_q),
        .span_en  (!first_q),
        .in_cnt   (in_cnt),
        .span_cnt (span_cnt),
        .hit      (hit)
    );

    // vld_q marks the cycle in which the byte fetched last cycle sits on mem_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            idx_q   <= '0;
            base_q  <= '0;
            pat_q   <= '0;
            prev_q  <= '0;
            first_q <= 1'b0;
            ctb_q   <= '0;
            cts_q   <= '0;
            cto_q   <= '0;
        end else begin
            vld_q <= (state_q == S_FETCH);
            if (accept) begin
                base_q  <= base_addr;
                pat_q   <= pat;
                idx_q   <= '0;
                prev_q  <= '0;
                first_q <= 1'b1;
                ctb_q   <= '0;
                cts_q   <= '0;
                cto_q   <= '0;
            end else begin
                if (state_q == S_FETCH) idx_q <= idx_q + IDX_W'(1);
                if (vld_q) begin
                    prev_q  <= mem.mem_rdata[2:0];
                    first_q <= 1'b0;
                    ctb_q   <= ctb_q + CNT_W'(in_cnt);
                    cts_q   <= cts_q + CNT_W'(in_cnt) + CNT_W'(span_cnt);
                    cto_q   <= cto_q + CNT_W'(hit);
                end
            end
        end
    end

    assign ctb = ctb_q;
    assign cts = cts_q;
    assign cto = cto_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Randomized bench for pattern_scan_ctrl against a bit-string reference model.
module tb_pattern_scan_ctrl;
    import prog3_pkg::*;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [3:0]        pat = '0;
    logic              busy, done;
    logic [CNT_W-1:0]  ctb, cts, cto;

    pattern_scan_ctrl_if #(.ADDR_W(ADDR_W)) mif ();

    pattern_scan_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .pat       (pat),
        .mem       (mif),
        .busy      (busy),
        .done      (done),
        .ctb       (ctb),
        .cts       (cts),
        .cto       (cto)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) if (mif.mem_re) mif.mem_rdata <= mem[mif.mem_addr];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] str_at(input logic [7:0] b);
        logic [63:0] s = '0;
        for (int j = 0; j < 8; j++) s = {s[55:0], mem[b + 8'(j)]};
        return s;
    endfunction

    // Counts over the first nb bytes of s; bit offset i counts from the MSB.
    function automatic void ref_counts(input logic [63:0] s, input int nb, input logic [3:0] p,
                                       output int cb, output int cs, output int co);
        bit [7:0] bh = '0;
        cb = 0; cs = 0; co = 0;
        for (int i = 0; i + 4 <= nb * 8; i++) begin
            if (s[63-i -: 4] == p) begin
                cs++;
                if ((i % 8) <= 4) begin
                    cb++;
                    bh[i/8] = 1'b1;
                end
            end
        end
        for (int k = 0; k < 8; k++) co += int'(bh[k]);
    endfunction

    bit          m_run = 1'b0;
    int          m_n = 0;
    logic [7:0]  m_base = '0;
    logic [3:0]  m_pat = '0;
    logic [63:0] m_str = '0;
    int          lb = 0, ls = 0, lo = 0;
    bit          chk_en = 1'b0;

    // Model timeline: m_n counts edges since the accepted start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0; m_n = 0; lb = 0; ls = 0; lo = 0;
        end else if (m_run) begin
            m_n++;
            if (m_n == 10) m_run = 1'b0;
        end else if (start) begin
            m_run = 1'b1; m_n = 0;
            m_base = base_addr; m_pat = pat;
            m_str = str_at(base_addr);
            lb = 0; ls = 0; lo = 0;
        end
    end

    always @(negedge clk) begin
        int k;
        bit ere;
        logic [7:0] ea;
        if (chk_en) begin
            if (m_run) begin
                k = (m_n >= 2) ? ((m_n - 1 > 8) ? 8 : m_n - 1) : 0;
                ref_counts(m_str, k, m_pat, lb, ls, lo);
            end
            ere = m_run && (m_n < 8);
            ea  = ere ? (m_base + 8'(m_n)) : 8'h00;
            chk("busy",     32'(busy),         32'(m_run));
            chk("done",     32'(done),         32'(m_run && (m_n == 9)));
            chk("mem_re",   32'(mif.mem_re),   32'(ere));
            chk("mem_addr", 32'(mif.mem_addr), 32'(ea));
            chk("ctb",      32'(ctb),          32'(8'(lb)));
            chk("cts",      32'(cts),          32'(8'(ls)));
            chk("cto",      32'(cto),          32'(8'(lo)));
        end
    end

    logic [7:0] addr_log [8];

    task automatic run_scan(input logic [7:0] b, input logic [3:0] p, input bit noise,
                            input int rst_at, output int cyc, output int re_cnt, output bit got_done);
        cyc = 0; re_cnt = 0; got_done = 1'b0;
        @(posedge clk); #1;
        base_addr = b; pat = p; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (noise) begin base_addr = 8'($urandom); pat = 4'($urandom); end
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (mif.mem_re) begin
                if (re_cnt < 8) addr_log[re_cnt] = mif.mem_addr;
                re_cnt++;
            end
            if (done) begin got_done = 1'b1; break; end
            if (cyc == rst_at) begin
                #2; rst_n = 1'b0; #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_re",   32'(mif.mem_re), 32'd0);
                chk("rst_cts",  32'(cts), 32'd0);
                break;
            end
            @(posedge clk); #1;
            if (noise) begin
                start = (cyc == 9) || ($urandom_range(0, 2) == 0);
                base_addr = 8'($urandom); pat = 4'($urandom);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic chk_counts(input string nm, input int eb, input int es, input int eo);
        chk({nm, "_ctb"}, 32'(ctb), 32'(eb));
        chk({nm, "_cts"}, 32'(cts), 32'(es));
        chk({nm, "_cto"}, 32'(cto), 32'(eo));
    endtask

    initial begin
        int cyc, re_cnt, ndone, rb, rs, ro;
        bit gd;
        logic [7:0] rbase;
        logic [3:0] rpat;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        chk_en = 1'b1;
        #3;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_addr", 32'(mif.mem_addr), 32'd0);
        chk_counts("reset", 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_scan(8'h10, 4'b1011, 1'b0, 0, cyc, re_cnt, gd);
        chk("zero_latency", 32'(cyc), 32'd10);
        chk("zero_re_cycles", 32'(re_cnt), 32'd8);
        chk("zero_done", 32'(gd), 32'd1);
        chk_counts("zero", 0, 0, 0);

        mem[8'h16] = 8'hB0;
        run_scan(8'h10, 4'b1011, 1'b0, 0, cyc, re_cnt, gd);
        chk_counts("single", 1, 1, 1);

        mem[8'h15] = 8'hBB;
        run_scan(8'h10, 4'b1011, 1'b0, 0, cyc, re_cnt, gd);
        chk_counts("double", 3, 3, 2);

        mem[8'h12] = 8'h02; mem[8'h13] = 8'hC0;
        ref_counts(str_at(8'h10), 8, 4'b1011, rb, rs, ro);
        chk("model_span_cts", 32'(rs), 32'd4);
        run_scan(8'h10, 4'b1011, 1'b0, 0, cyc, re_cnt, gd);
        chk_counts("span", 3, 4, 2);

        mem[8'h10] = 8'hBB;
        ref_counts(str_at(8'h10), 8, 4'b1011, rb, rs, ro);
        chk("model_b0_ctb", 32'(rb), 32'd5);
        run_scan(8'h10, 4'b1011, 1'b0, 0, cyc, re_cnt, gd);
        chk_counts("byte0", 5, 6, 3);

        mem[8'hFC] = 8'hBB; mem[8'h01] = 8'hB0;
        run_scan(8'hFC, 4'b1011, 1'b1, 0, cyc, re_cnt, gd);
        chk("wrap_addr0", 32'(addr_log[0]), 32'hFC);
        chk("wrap_addr4", 32'(addr_log[4]), 32'h00);
        chk("wrap_addr7", 32'(addr_log[7]), 32'h03);
        chk("wrap_latency", 32'(cyc), 32'd10);
        chk_counts("wrap", 3, 3, 2);

        run_scan(8'hFC, 4'b1011, 1'b0, 4, cyc, re_cnt, gd);
        chk("rst_no_done_in_run", 32'(gd), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_no_done_after", 32'(ndone), 32'd0);
        chk_counts("rst_hold", 0, 0, 0);

        for (int r = 0; r < 12; r++) begin
            rbase = 8'($urandom);
            rpat  = 4'($urandom);
            for (int j = 0; j < 8; j++)
                mem[rbase + 8'(j)] = ($urandom_range(0, 2) == 0) ? {rpat, rpat} : 8'($urandom);
            run_scan(rbase, rpat, 1'b1, 0, cyc, re_cnt, gd);
            ref_counts(str_at(rbase), 8, rpat, rb, rs, ro);
            chk("rand_done", 32'(gd), 32'd1);
            chk_counts("rand", rb, rs, ro);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
